// File: rtl/rv_program_loader.sv
// rv_program_loader
// Packs decoded RV32I instruction fields into 32-bit instruction words and
// writes them to consecutive instruction-memory words. The core is held
// until the program has been loaded.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   start               one-cycle pulse, begins a load session
//   in_valid/in_ready   field beat handshake (in_ready is registered)
//   in_fmt..in_last     decoded fields: format, opcode, funct3, funct7,
//                       rd/rs1/rs2, sign-extended immediate, last-beat flag
//   imem_we/addr/wdata  instruction-memory write port (one cycle after accept)
//   cpu_hold            keeps the core frozen while loading or after an abort
//   done, err           program loaded / load aborted
module rv_program_loader #(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_fmt,
  input  logic [6:0]  in_opcode,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [31:0] in_imm,
  input  logic        in_last,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        err
);

  // Counter must be able to hold DEPTH itself so overflow is detectable.
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE, S_ERROR} state_e;

  state_e        state_q;
  logic [CW-1:0] count_q;
  logic          in_ready_q, imem_we_q, cpu_hold_q, done_q, err_q;
  logic [31:0]   imem_addr_q, imem_wdata_q;

  logic [31:0]   wdata_d, addr_d;
  logic          fmt_legal;

  // Field packing; formats 6/7 are flagged illegal and never written.
  always_comb begin
    wdata_d   = 32'h0;
    fmt_legal = 1'b1;
    case (in_fmt)
      3'd0: wdata_d = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
      3'd1: wdata_d = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
      3'd2: wdata_d = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
      3'd3: wdata_d = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                       in_imm[4:1], in_imm[11], in_opcode};
      3'd4: wdata_d = {in_imm[31:12], in_rd, in_opcode};
      3'd5: wdata_d = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                       in_rd, in_opcode};
      default: fmt_legal = 1'b0;
    endcase
  end

  // Word address wraps modulo 2^32 by construction of the 32-bit add.
  assign addr_d = BASE_ADDR + (32'(count_q) << 2);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      count_q      <= '0;
      in_ready_q   <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= 32'h0;
      imem_wdata_q <= 32'h0;
      cpu_hold_q   <= 1'b1;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      imem_we_q <= 1'b0;  // strobe is one cycle wide
      case (state_q)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            state_q    <= S_LOAD;
            count_q    <= '0;
            in_ready_q <= 1'b1;
            cpu_hold_q <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
          end
        end
        S_LOAD: begin
          if (in_valid && in_ready_q) begin
            if (!fmt_legal || count_q == DEPTH_C) begin
              // Abort without writing; earlier words stay in memory.
              state_q    <= S_ERROR;
              in_ready_q <= 1'b0;
              err_q      <= 1'b1;
            end else begin
              imem_we_q    <= 1'b1;
              imem_addr_q  <= addr_d;
              imem_wdata_q <= wdata_d;
              count_q      <= count_q + CW'(1);
              if (in_last) begin
                state_q    <= S_DONE;
                in_ready_q <= 1'b0;
                done_q     <= 1'b1;
                cpu_hold_q <= 1'b0;
              end
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign cpu_hold   = cpu_hold_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_rv_program_loader.sv
// Bench for rv_program_loader. Two instances share the field bus:
// instance 0 (DEPTH=4, BASE=0) and instance 1 (DEPTH=1024, BASE=0x100),
// each with its own start pulse. A behavioural model tracks each instance
// and every output is compared one time unit after every rising edge.
module tb_rv_program_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_s [2];
  logic        in_valid = 1'b0;
  logic [2:0]  in_fmt = '0;
  logic [6:0]  in_opcode = '0;
  logic [2:0]  in_funct3 = '0;
  logic [6:0]  in_funct7 = '0;
  logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [31:0] in_imm = '0;
  logic        in_last = 1'b0;

  logic        rdy [2], we [2], hold [2], dn_o [2], er_o [2];
  logic [31:0] addr [2], wd [2];

  int ncmp = 0, nfail = 0;

  always #5 clk = ~clk;

  rv_program_loader #(.DEPTH(4), .BASE_ADDR(32'h0)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_s[0]), .in_valid(in_valid), .in_ready(rdy[0]),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_last(in_last),
    .imem_we(we[0]), .imem_addr(addr[0]), .imem_wdata(wd[0]), .cpu_hold(hold[0]),
    .done(dn_o[0]), .err(er_o[0]));

  rv_program_loader #(.DEPTH(1024), .BASE_ADDR(32'h100)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_s[1]), .in_valid(in_valid), .in_ready(rdy[1]),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_last(in_last),
    .imem_we(we[1]), .imem_addr(addr[1]), .imem_wdata(wd[1]), .cpu_hold(hold[1]),
    .done(dn_o[1]), .err(er_o[1]));

  // ---------------- reference model ----------------
  int unsigned dep  [2] = '{4, 1024};
  logic [31:0] base [2] = '{32'h0, 32'h100};
  bit          loading [2], finished [2], aborted [2];
  int unsigned nwords [2];
  logic        e_we [2];
  logic [31:0] e_addr [2], e_wd [2];

  // Instruction word assembled with shifts and masks from the field rules.
  function automatic logic [31:0] menc(input logic [31:0] fmt, op, f3, f7, rd, rs1, rs2, imm);
    logic [31:0] low;
    low = (f3 << 12) | (rs1 << 15) | op;
    case (fmt)
      0: return (f7 << 25) | (rs2 << 20) | low | (rd << 7);
      1: return ((imm & 32'hfff) << 20) | low | (rd << 7);
      2: return (((imm >> 5) & 32'h7f) << 25) | (rs2 << 20) | low | ((imm & 32'h1f) << 7);
      3: return (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3f) << 25) | (rs2 << 20) | low
              | (((imm >> 1) & 32'hf) << 8) | (((imm >> 11) & 1) << 7);
      4: return (imm & 32'hffff_f000) | (rd << 7) | op;
      default: return (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3ff) << 21)
              | (((imm >> 11) & 1) << 20) | (((imm >> 12) & 32'hff) << 12) | (rd << 7) | op;
    endcase
  endfunction

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        loading[k] = 0; finished[k] = 0; aborted[k] = 0; nwords[k] = 0;
        e_we[k] = 0; e_addr[k] = 0; e_wd[k] = 0;
      end else begin
        e_we[k] = 0;
        if (loading[k]) begin
          if (in_valid) begin
            if (in_fmt > 5 || nwords[k] == dep[k]) begin
              loading[k] = 0; aborted[k] = 1;
            end else begin
              e_we[k]   = 1;
              e_addr[k] = base[k] + 32'(4 * nwords[k]);
              e_wd[k]   = menc(32'(in_fmt), 32'(in_opcode), 32'(in_funct3), 32'(in_funct7),
                               32'(in_rd), 32'(in_rs1), 32'(in_rs2), in_imm);
              nwords[k]++;
              if (in_last) begin loading[k] = 0; finished[k] = 1; end
            end
          end
        end else if (start_s[k]) begin
          loading[k] = 1; finished[k] = 0; aborted[k] = 0; nwords[k] = 0;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s[%0d] observed=%h expected=%h", tag, k, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("in_ready", k, 32'(rdy[k]), 32'(loading[k]));
      chk("imem_we", k, 32'(we[k]), 32'(e_we[k]));
      chk("imem_addr", k, addr[k], e_addr[k]);
      chk("imem_wdata", k, wd[k], e_wd[k]);
      chk("cpu_hold", k, 32'(hold[k]), 32'(!finished[k]));
      chk("done", k, 32'(dn_o[k]), 32'(finished[k]));
      chk("err", k, 32'(er_o[k]), 32'(aborted[k]));
    end
  endtask

  task automatic pulse(input int k);
    start_s[k] = 1'b1; cyc(); start_s[k] = 1'b0;
  endtask

  task automatic beat(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [4:0] rd, rs1, rs2,
                      input logic [31:0] imm, input logic last);
    in_valid = 1; in_fmt = f; in_opcode = op; in_funct3 = f3; in_funct7 = f7;
    in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_last = last;
    cyc();
  endtask

  task automatic rbeat(input logic last);
    beat(3'($urandom_range(0, 5)), 7'($urandom), 3'($urandom), 7'($urandom),
         5'($urandom), 5'($urandom), 5'($urandom), $urandom, last);
  endtask

  task automatic idle(input int n);
    in_valid = 0; in_last = 0;
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic addi_last();
    beat(1, 7'b0010011, 0, 0, 1, 0, 0, 32'd5, 1);
  endtask

  initial begin
    start_s[0] = 0; start_s[1] = 0;
    // reset
    idle(2);
    chk("rst_ready", 0, 32'(rdy[0]), 0);
    chk("rst_hold", 0, 32'(hold[0]), 1);
    chk("rst_addr", 1, addr[1], 0);
    rst_n = 1;
    idle(1);

    // single addi, DEPTH=4 instance
    pulse(0);
    addi_last();
    chk("addi_we", 0, 32'(we[0]), 1);
    chk("addi_addr", 0, addr[0], 32'h0);
    chk("addi_wd", 0, wd[0], 32'h0050_0093);
    chk("addi_done", 0, 32'(dn_o[0]), 1);
    chk("addi_hold", 0, 32'(hold[0]), 0);
    idle(2);

    // six back-to-back beats at BASE 0x100
    pulse(1);
    beat(0, 7'b0110011, 0, 0, 3, 1, 2, 0, 0);
    chk("add_wd", 1, wd[1], 32'h0020_81B3);
    chk("add_addr", 1, addr[1], 32'h100);
    beat(2, 7'b0100011, 2, 0, 0, 1, 2, 32'd8, 0);
    chk("sw_wd", 1, wd[1], 32'h0020_A423);
    beat(3, 7'b1100011, 0, 0, 0, 1, 2, -32'sd4, 0);
    chk("beq_wd", 1, wd[1], 32'hFE20_8EE3);
    beat(5, 7'b1101111, 0, 0, 1, 0, 0, 32'd8, 0);
    chk("jal_wd", 1, wd[1], 32'h0080_00EF);
    beat(4, 7'b0110111, 0, 0, 5, 0, 0, 32'h1234_5000, 0);
    chk("lui_wd", 1, wd[1], 32'h1234_52B7);
    addi_last();
    chk("last_addr", 1, addr[1], 32'h114);
    chk("last_done", 1, 32'(dn_o[1]), 1);
    idle(2);

    // illegal format on second beat, then restart
    pulse(0);
    rbeat(0);
    beat(6, 7'h13, 0, 0, 1, 1, 1, 32'd1, 0);
    chk("ill_we", 0, 32'(we[0]), 0);
    chk("ill_err", 0, 32'(er_o[0]), 1);
    idle(2);
    pulse(0);
    chk("restart_err", 0, 32'(er_o[0]), 0);
    addi_last();
    chk("restart_addr", 0, addr[0], 32'h0);
    idle(1);

    // DEPTH=4: exact fill with last, then overflow
    pulse(0);
    for (int i = 0; i < 4; i++) rbeat(i == 3);
    chk("fill_done", 0, 32'(dn_o[0]), 1);
    chk("fill_addr", 0, addr[0], 32'hC);
    idle(1);
    pulse(0);
    for (int i = 0; i < 5; i++) rbeat(0);
    chk("ovf_we", 0, 32'(we[0]), 0);
    chk("ovf_err", 0, 32'(er_o[0]), 1);
    idle(2);

    // reset during the write cycle of the third beat
    pulse(0);
    for (int i = 0; i < 3; i++) rbeat(0);
    rst_n = 0;
    rbeat(0);
    chk("rstmid_we", 0, 32'(we[0]), 0);
    chk("rstmid_ready", 0, 32'(rdy[0]), 0);
    rst_n = 1;
    for (int i = 0; i < 3; i++) rbeat(0);
    chk("rstmid_ign", 0, 32'(we[0]), 0);
    idle(1);

    // random gaps, start pulsed mid-LOAD, both instances running
    start_s[0] = 1; start_s[1] = 1; cyc(); start_s[0] = 0; start_s[1] = 0;
    for (int i = 0; i < 60; i++) begin
      start_s[0] = (i == 20); start_s[1] = (i == 20) || (i == 37);
      if ($urandom_range(0, 2) != 0 || i == 59) rbeat(i == 59);
      else idle(1);
    end
    start_s[0] = 0; start_s[1] = 0;
    idle(1);
    chk("rand_done", 1, 32'(dn_o[1]), 1);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/rv_program_loader.md
# rv_program_loader

Sequential RISC-V instruction encoder and instruction-memory loader. Accepts decoded instruction fields (format, opcode, funct3, funct7, register indices, immediate) over a valid/ready stream. Packs each beat into a 32-bit RV32I instruction word and writes it to consecutive instruction-memory words. Holds the single-cycle core in hold until the program is complete. It is the encode side of the core's opcode/funct3/funct7 decode path.

## Interface
Parameters:
- DEPTH, 1024: instruction-memory capacity in words (≥2)
- BASE_ADDR, 32'h0000_0000: byte address of the first written word (word aligned)

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst_n  in  1  reset; synchronous and active-low
- start  in  1  one-cycle pulse; begins a load session
- in_valid  in  1  field beat valid
- in_ready  out  1  loader can accept a beat
- in_fmt  in  3  instruction format: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6 and 7 are illegal
- in_opcode  in  7  opcode field
- in_funct3  in  3  funct3 field
- in_funct7  in  7  funct7 field (R only)
- in_rd / in_rs1 / in_rs2  in  5 each  register indices
- in_imm  in  32  immediate, already sign-extended byte offset (U: upper 20 bits used)
- in_last  in  1  marks final beat of the program
- imem_we  out  1  instruction-memory write strobe
- imem_addr  out  32  byte write address
- imem_wdata  out  32  encoded instruction word
- cpu_hold  out  1  keeps core PC/regfile frozen
- done  out  1  program loaded
- err  out  1  load aborted (illegal format or overflow)

## Operation
- States: IDLE, LOAD, DONE, ERROR. Reset value is IDLE.
- IDLE: start → LOAD, word counter cleared to 0.
- LOAD: in_ready=1. A beat is accepted on in_valid && in_ready.
  - Legal accepted beat: encode, register the write for the next cycle, then count+1.
  - in_last on a legal beat → DONE.
  - Illegal in_fmt → ERROR, with no write.
  - Legal beat when count == DEPTH → ERROR (overflow), with no write. A last beat at index DEPTH-1 is legal.
- DONE: done=1, cpu_hold=0. start → LOAD (cpu_hold returns to 1, done=0, count=0).
- ERROR: err=1, cpu_hold=1. start → LOAD, which clears err. Words already written stay in memory.
- start in LOAD is ignored.
- Encoding of fields into the instruction word:
  - R: {funct7, rs2, rs1, funct3, rd, opcode}
  - I: {imm[11:0], rs1, funct3, rd, opcode}
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}
  - U: {imm[31:12], rd, opcode}
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}
- Unused fields are ignored. No range checking of the immediate: bits are truncated as listed.
- imem_addr = BASE_ADDR + 4*count, modulo 2^32.

## Timing
- Reset values:
  - state IDLE, count 0
  - in_ready 0, imem_we 0, imem_addr 0, imem_wdata 0
  - cpu_hold 1, done 0, err 0
- Latency: beat accepted at edge N produces imem_we=1 with its addr/wdata during cycle N+1. The strobe is one cycle wide.
- Throughput: one beat per cycle. Back-to-back beats give consecutive write cycles.
- in_ready is registered. It is 1 from the cycle after start is seen in IDLE/DONE/ERROR until the edge that accepts in_last, an illegal beat, or an overflow beat.
- done, err and cpu_hold change in the cycle after the terminating beat, coincident with the final write.
- imem_addr and imem_wdata hold their last values when imem_we=0.
- rst_n low at any edge, including mid-LOAD or during the final write cycle:
  - all outputs return to reset values at that edge
  - any pending write is dropped

## Test plan
- Reset then start, then one I beat (opcode 0010011, rd=1, rs1=0, imm=5, last) → one cycle later: imem_we=1, addr=0x0, wdata=0x00500093; done=1, cpu_hold=0.
- Six back-to-back beats, BASE_ADDR=0x100, in the order below → writes at 0x100..0x114 in order, no bubbles, done after the sixth:
  - add x3,x1,x2 → 0x002081B3
  - sw x2,8(x1) → 0x0020A423
  - beq x1,x2,-4 → 0xFE208EE3
  - jal x1,8 → 0x008000EF
  - lui x5,0x12345 (imm=0x12345000) → 0x123452B7
  - last beat: addi as in the first scenario → 0x00500093
- Second beat with in_fmt=6 → first write only, no second imem_we, err=1, cpu_hold=1. Then start clears err and reloads from BASE_ADDR.
- DEPTH=4:
  - 4 beats with the 4th last → done.
  - 5 beats with none last → 4 writes, 5th beat gives err=1 and no write.
- rst_n low for one cycle in the write cycle of the third of 5 beats → imem_we=0 at that edge onward, state IDLE, in_ready=0. Subsequent in_valid is ignored until start.
- in_valid toggling with gaps, and start pulsed mid-LOAD → writes only on accepted beats, addresses contiguous, start has no effect.
